// File: rtl/opcodes_pkg.sv
// RV32 opcode, funct and exact-encoding constants shared by the legality stage and its decoder.
package opcodes_pkg;

  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_FENCE    = OPC_MISC_MEM;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [6:0] OPC_AMO      = 7'h2f;

  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] SYS_MRET   = 32'h3020_0073;
  localparam logic [31:0] SYS_WFI    = 32'h1050_0073;

  typedef enum logic [6:0] {
    F7_BASE   = 7'h00,
    F7_MULDIV = 7'h01,
    F7_ALT    = 7'h20
  } funct7_e;

endpackage

// File: rtl/rv_legal_decode.sv
// Combinational RV32 legality classifier for the configured ISA subset (I + optional M, A, Zicsr).
module rv_legal_decode
  import opcodes_pkg::*;
#(
  parameter bit M_EXT = 1'b1,
  parameter bit A_EXT = 1'b1,
  parameter bit ZICSR = 1'b1
) (
  input  logic [31:0] instr,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] funct5;
  logic [4:0] rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct5 = instr[31:27];
  assign rs2    = instr[24:20];

  always_comb begin
    legal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      unique case (opcode)
        OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
        OPC_JALR:     legal = (funct3 == 3'b000);
        OPC_BRANCH:   legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        OPC_LOAD:     legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        OPC_STORE:    legal = (funct3 inside {3'b000, 3'b001, 3'b010});
        OPC_FENCE:    legal = (funct3 inside {3'b000, 3'b001});
        OPC_OP_IMM: begin
          // shifts carry funct7; SRAI is the only alternate encoding
          if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
          else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          else                       legal = 1'b1;
        end
        OPC_OP: begin
          if (funct7 == F7_BASE)        legal = 1'b1;
          else if (funct7 == F7_ALT)    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          else if (funct7 == F7_MULDIV) legal = M_EXT;
          else                          legal = 1'b0;
        end
        OPC_SYSTEM: begin
          if (funct3 == 3'b000)
            legal = (instr inside {SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_WFI});
          else if (funct3 == 3'b100)
            legal = 1'b0;
          else
            legal = ZICSR;
        end
        OPC_AMO: begin
          if (A_EXT && (funct3 == 3'b010)) begin
            legal = (funct5 inside {AMO_SC, AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
                                    AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU})
                 || ((funct5 == AMO_LR) && (rs2 == 5'd0));
          end
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/illegal_instr_stage.sv
// Registered legality stage: one-entry valid/ready pipe, first-fault trap capture.
// Optional saturating illegal counter enabled by ILLEGAL_INSTR_COUNTER_EN.
module illegal_instr_stage
  import opcodes_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          M_EXT     = 1'b1,
  parameter bit          A_EXT     = 1'b1,
  parameter bit          ZICSR     = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_instr_i,
  input  logic [XLEN-1:0]      in_pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_instr_o,
  output logic [XLEN-1:0]      out_pc_o,
  output logic                 out_illegal_o,
  output logic                 trap_valid_o,
  output logic [31:0]          trap_instr_o,
  output logic [XLEN-1:0]      trap_pc_o,
`ifdef ILLEGAL_INSTR_COUNTER_EN
  output logic [CNT_WIDTH-1:0] illegal_count_o,
`endif
  input  logic                 trap_ack_i
);

  logic legal;
  logic accept;
  logic out_hs;
  logic capture;

  rv_legal_decode #(
    .M_EXT(M_EXT),
    .A_EXT(A_EXT),
    .ZICSR(ZICSR)
  ) u_decode (
    .instr(in_instr_i),
    .legal(legal)
  );

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign out_hs     = out_valid_o && out_ready_i;
  assign capture    = out_hs && out_illegal_o;

  // pipeline register; flush wins over accept and drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o   <= 1'b0;
      out_instr_o   <= 32'd0;
      out_pc_o      <= '0;
      out_illegal_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o   <= 1'b1;
      out_instr_o   <= in_instr_i;
      out_pc_o      <= in_pc_i;
      out_illegal_o <= !legal;
    end else if (out_hs) begin
      out_valid_o <= 1'b0;
    end
  end

  // first-fault capture; an ack in the same cycle frees the slot for the new fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_valid_o <= 1'b0;
      trap_instr_o <= 32'd0;
      trap_pc_o    <= '0;
    end else if (capture && (!trap_valid_o || trap_ack_i)) begin
      trap_valid_o <= 1'b1;
      trap_instr_o <= out_instr_o;
      trap_pc_o    <= out_pc_o;
    end else if (trap_ack_i) begin
      trap_valid_o <= 1'b0;
    end
  end

`ifdef ILLEGAL_INSTR_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count_o <= '0;
    end else if (capture && (illegal_count_o != {CNT_WIDTH{1'b1}})) begin
      illegal_count_o <= illegal_count_o + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_illegal_instr_stage.sv
// Scoreboard bench: two configurations (full ISA / base only, 2-bit counter) share one stimulus stream.
module tb_illegal_instr_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;
  logic        trap_ack;

  logic        a_in_ready, a_out_valid, a_out_illegal, a_trap_valid;
  logic [31:0] a_out_instr, a_out_pc, a_trap_instr, a_trap_pc;
  logic        b_in_ready, b_out_valid, b_out_illegal, b_trap_valid;
  logic [31:0] b_out_instr, b_out_pc, b_trap_instr, b_trap_pc;
`ifdef ILLEGAL_INSTR_COUNTER_EN
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
`endif

  always #5 clk = ~clk;

  illegal_instr_stage #(.XLEN(32), .M_EXT(1'b1), .A_EXT(1'b1), .ZICSR(1'b1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_instr_o(a_out_instr), .out_pc_o(a_out_pc), .out_illegal_o(a_out_illegal),
    .trap_valid_o(a_trap_valid), .trap_instr_o(a_trap_instr), .trap_pc_o(a_trap_pc),
`ifdef ILLEGAL_INSTR_COUNTER_EN
    .illegal_count_o(a_cnt),
`endif
    .trap_ack_i(trap_ack)
  );

  illegal_instr_stage #(.XLEN(32), .M_EXT(1'b0), .A_EXT(1'b0), .ZICSR(1'b0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_instr_o(b_out_instr), .out_pc_o(b_out_pc), .out_illegal_o(b_out_illegal),
    .trap_valid_o(b_trap_valid), .trap_instr_o(b_trap_instr), .trap_pc_o(b_trap_pc),
`ifdef ILLEGAL_INSTR_COUNTER_EN
    .illegal_count_o(b_cnt),
`endif
    .trap_ack_i(trap_ack)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          ill_a;
    bit          ill_b;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mv;
  bit          tv_a, tv_b;
  logic [31:0] ti_a, tp_a, ti_b, tp_b;
  int          cnt_a, cnt_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written straight from the ISA subset table.
  function automatic bit ref_legal(input logic [31:0] w, input bit m, input bit a, input bit z);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] f5;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; f5 = w[31:27];
    if (w[1:0] != 2'b11) return 1'b0;
    case (op)
      7'h37, 7'h17, 7'h6f: return 1'b1;
      7'h67: return f3 == 3'd0;
      7'h63: return !(f3 == 3'd2 || f3 == 3'd3);
      7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23: return f3 <= 3'd2;
      7'h0f: return f3 <= 3'd1;
      7'h13: begin
        if (f3 == 3'd1) return f7 == 7'd0;
        if (f3 == 3'd5) return f7 == 7'd0 || f7 == 7'd32;
        return 1'b1;
      end
      7'h33: return (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'd1 && m);
      7'h73: begin
        if (f3 == 3'd0) return w == 32'h73 || w == 32'h0010_0073 || w == 32'h3020_0073 || w == 32'h1050_0073;
        if (f3 == 3'd4) return 1'b0;
        return z;
      end
      7'h2f: return a && f3 == 3'd2 &&
                    ((f5 inside {5'd3, 5'd1, 5'd0, 5'd4, 5'd12, 5'd8, 5'd16, 5'd20, 5'd24, 5'd28}) ||
                     (f5 == 5'd2 && w[24:20] == 5'd0));
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    out_ready = 1'b0; trap_ack = 1'b0;
    q.delete(); mv = 1'b0;
    tv_a = 1'b0; tv_b = 1'b0; ti_a = 32'd0; tp_a = 32'd0; ti_b = 32'd0; tp_b = 32'd0;
    cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_instr", a_out_instr, 32'd0);
    chk("rst_out_illegal", 32'(a_out_illegal), 32'd0);
    chk("rst_trap_valid", 32'(b_trap_valid), 32'd0);
    chk("rst_trap_pc", a_trap_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one cycle, check the handshake side, and push the expected output entry.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit ack);
    bit rdy;
    @(posedge clk); #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; trap_ack = ack;
    @(negedge clk);
    rdy = !mv || ordy;
    chk("in_ready_a", 32'(a_in_ready), 32'(rdy));
    chk("in_ready_b", 32'(b_in_ready), 32'(rdy));
    chk("out_valid_a", 32'(a_out_valid), 32'(mv));
    chk("out_valid_b", 32'(b_out_valid), 32'(mv));
    if (mv && q.size() > 0) begin
      chk("held_instr", a_out_instr, q[0].instr);
      chk("held_pc", b_out_pc, q[0].pc);
    end
    if (fl) begin
      if (mv && q.size() > 0) void'(q.pop_front());
      mv = 1'b0;
    end else if (v && rdy) begin
      q.push_back('{instr: ins, pc: pc, ill_a: !ref_legal(ins, 1'b1, 1'b1, 1'b1),
                    ill_b: !ref_legal(ins, 1'b0, 1'b0, 1'b0)});
      mv = 1'b1;
    end else if (mv && ordy) begin
      mv = 1'b0;
    end
  endtask

  // Monitor: trap/counter state every cycle, output payload on each output handshake.
  initial begin
    exp_t e;
    bit   cap_a, cap_b;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        chk("trap_valid_a", 32'(a_trap_valid), 32'(tv_a));
        chk("trap_instr_a", a_trap_instr, ti_a);
        chk("trap_pc_a", a_trap_pc, tp_a);
        chk("trap_valid_b", 32'(b_trap_valid), 32'(tv_b));
        chk("trap_instr_b", b_trap_instr, ti_b);
        chk("trap_pc_b", b_trap_pc, tp_b);
`ifdef ILLEGAL_INSTR_COUNTER_EN
        chk("count_a", 32'(a_cnt), 32'(cnt_a));
        chk("count_b", 32'(b_cnt), 32'(cnt_b));
`endif
        cap_a = 1'b0; cap_b = 1'b0;
        if (a_out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("queue_underflow", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("out_instr", a_out_instr, e.instr);
            chk("out_pc", a_out_pc, e.pc);
            chk("out_illegal_a", 32'(a_out_illegal), 32'(e.ill_a));
            chk("out_illegal_b", 32'(b_out_illegal), 32'(e.ill_b));
            cap_a = e.ill_a; cap_b = e.ill_b;
          end
        end
        if (cap_a && (!tv_a || trap_ack)) begin
          tv_a = 1'b1; ti_a = e.instr; tp_a = e.pc;
        end else if (trap_ack) tv_a = 1'b0;
        if (cap_b && (!tv_b || trap_ack)) begin
          tv_b = 1'b1; ti_b = e.instr; tp_b = e.pc;
        end else if (trap_ack) tv_b = 1'b0;
        if (cap_a && cnt_a < 65535) cnt_a++;
        if (cap_b && cnt_b < 3) cnt_b++;
      end
    end
  end

  function automatic logic [31:0] rand_word();
    logic [6:0] ops [12];
    logic [31:0] w;
    int unsigned r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0f, 7'h13, 7'h33, 7'h73, 7'h2f};
    w = $urandom;
    r = $urandom_range(0, 15);
    if (r == 0) return w;
    if (r == 1) begin
      case ($urandom_range(0, 3))
        0: return 32'h0000_0073;
        1: return 32'h0010_0073;
        2: return 32'h3020_0073;
        default: return 32'h1050_0073;
      endcase
    end
    w[6:0] = ops[$urandom_range(0, 11)];
    case ($urandom_range(0, 4))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h01;
      2: w[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
    return w;
  endfunction

  initial begin
    bit v, ordy, fl, ack;
    do_reset();
    // addi, mul, then a bubble
    step(1, 32'h0000_0013, 32'h100, 1, 0, 0);
    step(1, 32'h02A5_8533, 32'h104, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // lw, funct3 011 load, SYSTEM funct3 100
    step(1, 32'h0000_2003, 32'h200, 1, 0, 0);
    step(1, 32'h0000_3003, 32'h204, 1, 0, 0);
    step(1, 32'h0000_4073, 32'h208, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // ack alone, then two illegal words back to back with no ack
    step(0, 32'h0, 32'h0, 1, 0, 1);
    step(1, 32'hFFFF_FFFF, 32'h300, 1, 0, 0);
    step(1, 32'h0000_007F, 32'h304, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // ack in the same cycle as a new illegal handshake
    step(1, 32'h0000_5023, 32'h400, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // stall for 3 cycles, then flush while stalled
    step(1, 32'h0000_0013, 32'h500, 1, 0, 0);
    step(1, 32'h0000_3003, 32'h504, 0, 0, 0);
    step(1, 32'h0000_3003, 32'h504, 0, 0, 0);
    step(1, 32'h0000_3003, 32'h504, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // saturate the narrow counter with a burst of illegal words
    for (int i = 0; i < 5; i++) step(1, 32'h0000_4073, 32'h600 + 32'(4 * i), 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    // reset mid-transfer with a fault captured and an entry held
    step(1, 32'h0000_3003, 32'h700, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = !ordy && ($urandom_range(0, 7) == 0);
      ack  = ($urandom_range(0, 5) == 0);
      step(v, rand_word(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ordy, fl, ack);
    end
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0, 0);
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
